keypad_time_entry: RTL

//  Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 matrix keypad
//  (drives rows, reads columns), debounces it and assembles HH:MM:SS as 8-bit packed BCD.
//  A validated entry is committed with a 1-cycle LOAD pulse. D_H/D_M/D_S feed the timer

---
 rtl/keypad_time_entry_pkg.sv | 64 ++++++
 rtl/keypad_time_entry_scanner.sv | 129 ++++++++++++
 rtl/keypad_time_entry.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/keypad_time_entry_pkg.sv
// Shared definitions for the keypad time-entry block.
// Contents: key code constants, entry FSM state encodings, keypad map helper
// and the HH:MM:SS plausibility check used on commit.
package keypad_time_entry_pkg;

    localparam logic [4:0] KEY_0    = 5'h00;
    localparam logic [4:0] KEY_1    = 5'h01;
    localparam logic [4:0] KEY_2    = 5'h02;
    localparam logic [4:0] KEY_3    = 5'h03;
    localparam logic [4:0] KEY_4    = 5'h04;
    localparam logic [4:0] KEY_5    = 5'h05;
    localparam logic [4:0] KEY_6    = 5'h06;
    localparam logic [4:0] KEY_7    = 5'h07;
    localparam logic [4:0] KEY_8    = 5'h08;
    localparam logic [4:0] KEY_9    = 5'h09;
    localparam logic [4:0] KEY_A    = 5'h0A;
    localparam logic [4:0] KEY_B    = 5'h0B;
    localparam logic [4:0] KEY_C    = 5'h0C;
    localparam logic [4:0] KEY_D    = 5'h0D;
    localparam logic [4:0] KEY_STAR = 5'h0E;
    localparam logic [4:0] KEY_HASH = 5'h0F;
    localparam logic [4:0] KEY_NONE = 5'h10;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ENTER = 1'b1;

    // Physical layout, row0..3 x col0..3:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [4:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        case ({r, c})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = KEY_A;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = KEY_B;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // Buffer layout: [23:20] H tens, [19:16] H units, [15:12] M tens,
    // [11:8] M units, [7:4] S tens, [3:0] S units. Units are always 0..9
    // because only digit keys are written into the buffer.
    function automatic logic time_valid(input logic [23:0] b, input logic [2:0] idx);
        logic ok;
        ok = (idx == 3'd6);
        if (b[23:20] > 4'd2) ok = 1'b0;
        if ((b[23:20] == 4'd2) && (b[19:16] > 4'd3)) ok = 1'b0;
        if (b[15:12] > 4'd5) ok = 1'b0;
        if (b[7:4] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/keypad_time_entry_scanner.sv
// Keypad row scanner and debouncer.
// Drives one row low at a time, samples the columns on the last cycle of
// each row slot, resolves the first pressed key of the frame (row-major)
// and debounces frame codes into a single key event per press.
// Ports:
//   clk, rst     clock, async active-high reset
//   col[3:0]     keypad columns, active-low
//   row[3:0]     keypad rows, active-low one-cold
//   key_valid    1-cycle key event
//   key_code     code of the key that produced the event
//   frame_tick   1-cycle pulse, aligned with key_valid, once per frame
module keypad_scanner
    import keypad_time_entry_pkg::*;
#(
    parameter int SCAN_DIV = 50,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [4:0] key_code,
    output logic       frame_tick
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [4:0]    acc_q, acc_d;
    logic [4:0]    last_q, last_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          latch_q, latch_d;
    logic          key_valid_q, key_valid_d;
    logic [4:0]    key_code_q, key_code_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          frame_end;
    logic [4:0]    code_row;
    logic [4:0]    frame_code;
    logic [DW-1:0] cnt_new;

    always_comb begin
        slot_end  = (slot_q == '0);
        frame_end = slot_end && (row_idx_q == 2'd3);

        // Lowest active column of the row currently driven.
        code_row = KEY_NONE;
        for (int c = 3; c >= 0; c--) begin
            if (!col[c]) code_row = key_map(row_idx_q, 2'(c));
        end

        // Earlier rows in the frame win over the current one.
        frame_code = (acc_q != KEY_NONE) ? acc_q : code_row;

        if (frame_code == last_q) begin
            cnt_new = (cnt_q == DW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_new = DW'(1);
        end

        slot_d       = slot_q;
        row_idx_d    = row_idx_q;
        acc_d        = acc_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        latch_d      = latch_q;
        key_valid_d  = 1'b0;
        key_code_d   = key_code_q;
        frame_tick_d = 1'b0;

        if (slot_end) begin
            slot_d    = SW'(SCAN_DIV - 1);
            row_idx_d = row_idx_q + 2'd1;
            if (frame_end) begin
                acc_d        = KEY_NONE;
                frame_tick_d = 1'b1;
                last_d       = frame_code;
                cnt_d        = cnt_new;
                if (cnt_new == DW'(DEBOUNCE)) begin
                    if (frame_code == KEY_NONE) begin
                        latch_d = 1'b0;
                    end else if (!latch_q) begin
                        key_valid_d = 1'b1;
                        key_code_d  = frame_code;
                        latch_d     = 1'b1;
                    end
                end
            end else begin
                acc_d = frame_code;
            end
        end else begin
            slot_d = slot_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= SW'(SCAN_DIV - 1);
            row_idx_q    <= 2'd0;
            acc_q        <= KEY_NONE;
            last_q       <= KEY_NONE;
            cnt_q        <= '0;
            latch_q      <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= KEY_NONE;
            frame_tick_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            row_idx_q    <= row_idx_d;
            acc_q        <= acc_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign row        = ~(4'b0001 << row_idx_q);
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: assembles HH:MM:SS (packed BCD) from a 4x4 keypad and
// commits a validated value with a 1-cycle LOAD pulse.
// Ports:
//   CP          clock (scan clock)
//   CR          async active-high reset
//   COL[3:0]    keypad columns, active-low
//   ROW[3:0]    keypad rows, active-low one-cold
//   D_H/D_M/D_S committed hours/minutes/seconds, packed BCD
//   LOAD        1-cycle commit pulse, D_* already carry the new value
//   ENTRY       high while an entry is in progress
//   DIGIT_IDX   digits entered so far (0..6)
//   ERR         1-cycle pulse on a rejected commit
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for '*', D_* hold the last committed time
// ST_ENTER | collecting digits; '#' commits, '*' restarts, timeout aborts
module keypad_time_entry
    import keypad_time_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 50,
    parameter int DEBOUNCE       = 4,
    parameter int TIMEOUT_FRAMES = 500
) (
    input  logic       CP,
    input  logic       CR,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [7:0] D_H,
    output logic [7:0] D_M,
    output logic [7:0] D_S,
    output logic       LOAD,
    output logic       ENTRY,
    output logic [2:0] DIGIT_IDX,
    output logic       ERR
);

    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    logic       key_valid;
    logic [4:0] key_code;
    logic       frame_tick;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scanner (
        .clk        (CP),
        .rst        (CR),
        .col        (COL),
        .row        (ROW),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .frame_tick (frame_tick)
    );

    logic [0:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   buf_q, buf_d;
    logic [7:0]    d_h_q, d_h_d;
    logic [7:0]    d_m_q, d_m_d;
    logic [7:0]    d_s_q, d_s_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          is_digit;
    logic          key_accepted;

    always_comb begin
        is_digit     = (key_code <= KEY_9);
        // A-D never count as activity, so they cannot hold off the timeout.
        key_accepted = key_valid && (is_digit || key_code == KEY_STAR || key_code == KEY_HASH);

        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        d_h_d   = d_h_q;
        d_m_d   = d_m_q;
        d_s_d   = d_s_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = 3'd0;
                if (key_valid && key_code == KEY_STAR) begin
                    state_d = ST_ENTER;
                    buf_d   = '0;
                    idx_d   = 3'd0;
                    tmo_d   = TW'(TIMEOUT_FRAMES);
                end
            end
            ST_ENTER: begin
                if (key_accepted) begin
                    tmo_d = TW'(TIMEOUT_FRAMES);
                    if (is_digit) begin
                        if (idx_q < 3'd6) begin
                            case (idx_q)
                                3'd0:    buf_d[23:20] = key_code[3:0];
                                3'd1:    buf_d[19:16] = key_code[3:0];
                                3'd2:    buf_d[15:12] = key_code[3:0];
                                3'd3:    buf_d[11:8]  = key_code[3:0];
                                3'd4:    buf_d[7:4]   = key_code[3:0];
                                default: buf_d[3:0]   = key_code[3:0];
                            endcase
                            idx_d = idx_q + 3'd1;
                        end
                    end else if (key_code == KEY_STAR) begin
                        buf_d = '0;
                        idx_d = 3'd0;
                    end else begin
                        if (time_valid(buf_q, idx_q)) begin
                            load_d  = 1'b1;
                            d_h_d   = buf_q[23:16];
                            d_m_d   = buf_q[15:8];
                            d_s_d   = buf_q[7:0];
                            state_d = ST_IDLE;
                        end else begin
                            err_d = 1'b1;
                        end
                        buf_d = '0;
                        idx_d = 3'd0;
                    end
                end else if (frame_tick) begin
                    // Down-counter: abort on the frame that would reach zero.
                    if (tmo_q <= TW'(1)) begin
                        state_d = ST_IDLE;
                        buf_d   = '0;
                        idx_d   = 3'd0;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                buf_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            buf_q   <= '0;
            d_h_q   <= 8'h00;
            d_m_q   <= 8'h00;
            d_s_q   <= 8'h00;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            d_h_q   <= d_h_d;
            d_m_q   <= d_m_d;
            d_s_q   <= d_s_d;
            load_q  <= load_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign D_H       = d_h_q;
    assign D_M       = d_m_q;
    assign D_S       = d_s_q;
    assign LOAD      = load_q;
    assign ERR       = err_q;
    assign ENTRY     = (state_q == ST_ENTER);
    assign DIGIT_IDX = idx_q;

endmodule
